// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory port between the instruction-fetch (IF) and the
// data-memory (DM) requesters of the pipeline CPU. One requester at a time is
// granted the port, its address / write enable / write data are latched, and a
// fixed-latency access is sequenced. Read data is returned together with a
// one-cycle done pulse. Under contention the grant alternates, so neither
// requester waits longer than one transaction.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   LATENCY  memory busy cycles per access (1..255)
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   if_req_i, if_addr_i        IF read request (held until grant) and address
//   if_gnt_o, if_done_o        IF one-cycle grant / completion pulses
//   if_rdata_o                 IF read data, valid with if_done_o, then held
//   dm_req_i, dm_we_i          DM request (held until grant), write enable
//   dm_addr_i, dm_wdata_i      DM address and write data
//   dm_gnt_o, dm_done_o        DM one-cycle grant / completion pulses
//   dm_rdata_o                 DM read data, valid with dm_done_o, then held
//   mem_en_o, mem_we_o         memory access active / write strobe
//   mem_sel_o                  shared address/data mux select (0 = IF, 1 = DM)
//   mem_addr_o, mem_wdata_o    latched access address / write data
//   mem_rdata_i                memory read data, valid in the last busy cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_done_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic              mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    // Counter value of the final busy cycle.
    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic       last_dm_q;   // 1 = last grant went to DM, 0 = to IF
    logic       we_q;        // latched write enable, always 0 for IF
    logic       grant_if, grant_dm, finish;

    // Next-state, arbitration and memory-side control outputs.
    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        finish    = 1'b0;
        mem_en_o  = 1'b0;
        mem_we_o  = 1'b0;
        mem_sel_o = 1'b0;
        case (state_q)
            IDLE: begin
                // DM wins when alone, or when both ask and IF had the last turn.
                if (dm_req_i && (!if_req_i || !last_dm_q)) begin
                    grant_dm = 1'b1;
                    state_d  = BUSY_DM;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                    state_d  = BUSY_IF;
                end
            end
            BUSY_IF: begin
                mem_en_o = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_DM: begin
                mem_en_o  = 1'b1;
                mem_sel_o = 1'b1;
                mem_we_o  = we_q;
                if (cnt_q == LAST_CNT) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched access fields and registered requester-side pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_dm_q   <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_gnt_o    <= 1'b0;
            dm_gnt_o    <= 1'b0;
            if_done_o   <= 1'b0;
            dm_done_o   <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            state_q   <= state_d;
            if_gnt_o  <= grant_if;
            dm_gnt_o  <= grant_dm;
            if_done_o <= finish && (state_q == BUSY_IF);
            dm_done_o <= finish && (state_q == BUSY_DM);

            if (grant_if) begin
                mem_addr_o <= if_addr_i;
                we_q       <= 1'b0;
                cnt_q      <= '0;
                last_dm_q  <= 1'b0;
            end else if (grant_dm) begin
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
                we_q        <= dm_we_i;
                cnt_q       <= '0;
                last_dm_q   <= 1'b1;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + 8'd1;
            end

            // Writes complete without touching the returned read data.
            if (finish && (state_q == BUSY_IF)) begin
                if_rdata_o <= mem_rdata_i;
            end
            if (finish && (state_q == BUSY_DM) && !we_q) begin
                dm_rdata_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    // LATENCY = 2 instance
    logic        if_req, if_gnt, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_done;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // LATENCY = 1 instance
    logic        l1_if_req, l1_if_gnt, l1_if_done;
    logic [31:0] l1_if_addr, l1_if_rdata;
    logic        l1_dm_req, l1_dm_we, l1_dm_gnt, l1_dm_done;
    logic [31:0] l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
    logic        l1_mem_en, l1_mem_we, l1_mem_sel;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt), .if_done_o(if_done), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_done_o(dm_done), .dm_rdata_o(dm_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_sel_o(mem_sel),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(l1_if_req), .if_addr_i(l1_if_addr),
        .if_gnt_o(l1_if_gnt), .if_done_o(l1_if_done), .if_rdata_o(l1_if_rdata),
        .dm_req_i(l1_dm_req), .dm_we_i(l1_dm_we), .dm_addr_i(l1_dm_addr), .dm_wdata_i(l1_dm_wdata),
        .dm_gnt_o(l1_dm_gnt), .dm_done_o(l1_dm_done), .dm_rdata_o(l1_dm_rdata),
        .mem_en_o(l1_mem_en), .mem_we_o(l1_mem_we), .mem_sel_o(l1_mem_sel),
        .mem_addr_o(l1_mem_addr), .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(l1_mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge: outputs then show the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, 64'({if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, mem_sel}), 64'd0);
        chk({tag, ".bus"}, {mem_addr, mem_wdata}, 64'd0);
        chk({tag, ".rd"},  {if_rdata, dm_rdata}, 64'd0);
        chk({tag, ".l1ctl"}, 64'({l1_if_gnt, l1_if_done, l1_dm_gnt, l1_dm_done,
                                  l1_mem_en, l1_mem_we, l1_mem_sel}), 64'd0);
        chk({tag, ".l1bus"}, {l1_mem_addr, l1_mem_wdata}, 64'd0);
        chk({tag, ".l1rd"},  {l1_if_rdata, l1_dm_rdata}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_wdata = 32'h0;
        mem_rdata = 32'h0;
        l1_if_req = 1'b0; l1_if_addr = 32'h0;
        l1_dm_req = 1'b0; l1_dm_we = 1'b0; l1_dm_addr = 32'h0; l1_dm_wdata = 32'h0;
        l1_mem_rdata = 32'h0;

        // ---- Test 1: reset with both requests high
        step(); chk_all_zero("rst_c1");
        step(); chk_all_zero("rst_c2");
        rst = 1'b0;
        chk("t1_no_gnt_release", 64'({if_gnt, dm_gnt}), 64'd0);
        step();
        chk("t1_first_gnt_dm", 64'({if_gnt, dm_gnt}), 64'b01);
        chk("t1_sel_dm", 64'({mem_en, mem_sel}), 64'b11);
        chk("t1_addr", 64'(mem_addr), 64'h20);
        if_req = 1'b0; dm_req = 1'b0;
        mem_rdata = 32'h0BADF00D;
        step();
        chk("t1_busy_no_done", 64'({dm_gnt, dm_done, mem_en}), 64'b001);
        step();
        chk("t1_done", 64'({dm_done, if_done, mem_en}), 64'b100);
        chk("t1_rdata", 64'(dm_rdata), 64'h0BADF00D);
        mem_rdata = 32'h0;
        step();

        // ---- Test 2: single IF read (cycle 0 = now)
        if_req = 1'b1; if_addr = 32'h40;
        chk("t2_c0_idle", 64'({if_gnt, mem_en}), 64'd0);
        step();
        chk("t2_c1_gnt", 64'({if_gnt, dm_gnt, if_done}), 64'b100);
        chk("t2_c1_mem", 64'({mem_en, mem_sel, mem_we}), 64'b100);
        chk("t2_c1_addr", 64'(mem_addr), 64'h40);
        if_req = 1'b0;
        step();
        chk("t2_c2_mem", 64'({if_gnt, if_done, mem_en, mem_sel}), 64'b0010);
        chk("t2_c2_addr", 64'(mem_addr), 64'h40);
        mem_rdata = 32'hDEADBEEF;
        step();
        chk("t2_c3_done", 64'({if_done, mem_en}), 64'b10);
        chk("t2_c3_rdata", 64'(if_rdata), 64'hDEADBEEF);
        mem_rdata = 32'h0;
        step();
        chk("t2_c4_hold", 64'({if_done, if_rdata}), {31'd0, 1'b0, 32'hDEADBEEF});

        // ---- Test 3: contention, DM write vs IF read (cycle 0 = now)
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h1234;
        if_req = 1'b1; if_addr = 32'h80;
        step();
        chk("t3_c1_gnt", 64'({if_gnt, dm_gnt}), 64'b01);
        chk("t3_c1_mem", 64'({mem_en, mem_we, mem_sel}), 64'b111);
        chk("t3_c1_bus", {mem_addr, mem_wdata}, {32'h100, 32'h1234});
        dm_req = 1'b0;
        step();
        chk("t3_c2_mem", 64'({mem_en, mem_we, mem_sel}), 64'b111);
        mem_rdata = 32'hFFFFFFFF;
        step();
        chk("t3_c3_done", 64'({dm_done, if_gnt, mem_en, mem_we}), 64'b1000);
        chk("t3_c3_wr_no_rdata", 64'(dm_rdata), 64'h0BADF00D);
        mem_rdata = 32'h22222222;
        step();
        chk("t3_c4_if_gnt", 64'({if_gnt, dm_gnt, mem_sel, mem_we}), 64'b1000);
        chk("t3_c4_addr", 64'(mem_addr), 64'h80);
        if_req = 1'b0;
        step();
        chk("t3_c5_busy", 64'({if_done, mem_en}), 64'b01);
        step();
        chk("t3_c6_done", 64'({if_done, dm_done}), 64'b10);
        chk("t3_c6_rdata", 64'(if_rdata), 64'h22222222);

        // ---- Test 4: both held continuously (cycle 0 = now, last grant was IF)
        dm_we = 1'b0; dm_req = 1'b1; if_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("t4_dm_gnt_c%0d", i), 64'(dm_gnt), 64'((i == 1) || (i == 7)));
            chk($sformatf("t4_if_gnt_c%0d", i), 64'(if_gnt), 64'((i == 4) || (i == 10)));
            chk($sformatf("t4_en_c%0d", i), 64'(mem_en), 64'((i % 3) != 0));
            chk($sformatf("t4_sel_c%0d", i), 64'(mem_sel), 64'(((i % 6) == 1) || ((i % 6) == 2)));
            chk($sformatf("t4_done_c%0d", i), 64'({dm_done, if_done}),
                64'({(i == 3) || (i == 9), (i == 6) || (i == 12)}));
            if (i == 12) begin
                dm_req = 1'b0; if_req = 1'b0;
            end
        end
        step();
        chk("t4_quiet", 64'({if_gnt, dm_gnt, mem_en}), 64'd0);

        // ---- Test 5: reset during BUSY_DM (cycle 0 = now)
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        step();
        chk("t5_c1_gnt", 64'(dm_gnt), 64'd1);
        step();
        chk("t5_c2_busy", 64'({mem_en, mem_sel}), 64'b11);
        rst = 1'b1;
        step();
        chk("t5_c3_abort", 64'({mem_en, dm_done, dm_gnt}), 64'd0);
        rst = 1'b0;
        step();
        chk("t5_c4_regnt", 64'({dm_gnt, dm_done}), 64'b10);
        dm_req = 1'b0;
        step();
        chk("t5_c5_busy", 64'({dm_done, mem_en}), 64'b01);
        step();
        chk("t5_c6_done", 64'(dm_done), 64'd1);

        // ---- Test 6: LATENCY=1 DM read (cycle 0 = now)
        l1_dm_req = 1'b1; l1_dm_we = 1'b0; l1_dm_addr = 32'h8;
        l1_mem_rdata = 32'hA5A5A5A5;
        step();
        chk("t6_c1_gnt", 64'({l1_dm_gnt, l1_dm_done, l1_mem_en, l1_mem_sel}), 64'b1011);
        chk("t6_c1_addr", 64'(l1_mem_addr), 64'h8);
        l1_dm_req = 1'b0;
        step();
        chk("t6_c2_done", 64'({l1_dm_done, l1_dm_gnt, l1_mem_en}), 64'b100);
        chk("t6_c2_rdata", 64'(l1_dm_rdata), 64'hA5A5A5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
